seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receiving end of the board's 7-segment display interface.
- Samples the multiplexed anode/segment pins of an 8-digit scanned display, filters scan transitions and ghosting, and decodes each digit's segment pattern back to a 4-bit value.
- Provides a parallel 8-digit snapshot plus a frame-complete strobe.
- Used as an on-chip monitor for display drivers and as a bench checker for them.

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles the anode/segment pair must be stable before capture. Legal range 2..65535; stability counter width = $clog2(SETTLE_CYCLES+1).

Ports:
- CLK100MHZ  input  1  system clock
- RST  input  1  asynchronous active-high reset
- AN_IN  input  8  anode lines, active-low, bit i = digit i
- SEG_IN  input  7  segments {a,b,c,d,e,f,g} = bits [6:0], active-low
- DIGITS  output  32  decoded values, digit i at [4i+3:4i]
- DIGIT_VALID  output  8  bit i = last capture of digit i decoded to a known pattern
- FRAME_DONE  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse
- ERR  output  1  one-cycle pulse on an unknown pattern or an illegal anode value

Behaviour:
- Reset and clocking:
  - One clock, CLK100MHZ. RST is asynchronous and active-high.
  - Reset values: DIGITS=0, DIGIT_VALID=0, FRAME_DONE=0, ERR=0, synchronizer flops all ones (blank), stability counter=0, seen mask=0.
- Input stage: AN_IN and SEG_IN pass through a 2-flop synchronizer. The second-stage pair P is the sampled value.
- Stability counter:
  - If P differs from the previous-cycle P, the counter clears to 0.
  - Otherwise it increments, saturating at SETTLE_CYCLES-1.
  - A capture strobe fires on the single cycle the counter goes from SETTLE_CYCLES-2 to SETTLE_CYCLES-1. There is exactly one strobe per stable window.
- Latency: if the pins change and then hold, outputs update on the edge SETTLE_CYCLES+2 cycles after the change. A glitch shorter than SETTLE_CYCLES cycles produces no capture.
- Anode classification at the strobe:
  - Exactly one bit low, index i: digit capture.
  - All ones: blank, no action.
  - Any other value: ERR pulses; DIGITS, DIGIT_VALID and the seen mask are unchanged.
- Segment decode, active-low a..g:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Any other pattern: value 4'hF, DIGIT_VALID[i]=0, ERR pulses.
  - Known pattern: DIGIT_VALID[i]=1.
- Digit capture: DIGITS[4i+3:4i] and DIGIT_VALID[i] are registered on the strobe edge, and seen[i] is set.
  - Recapturing digit i before the frame completes overwrites its value; the seen mask is unchanged.
- Frame completion:
  - When the seen mask including the current capture is 8'hFF, FRAME_DONE pulses in the same cycle the digit updates, and the seen mask clears to 0.
  - ERR and FRAME_DONE may pulse in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. A partially seen frame is discarded.

Optional Feature:
- Macro SEG7_SCAN_HEX_EN.
- Defined: the decoder also accepts A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, decoded to values A..F with DIGIT_VALID=1.
- Undefined: these six patterns are unknown (value F, DIGIT_VALID=0, ERR pulse).
- No port changes in either case.

Test Plan:
- Scan with SETTLE_CYCLES=4: drive AN_IN=11111110, SEG_IN=0010010 for 10 cycles → DIGITS[3:0]=2 and DIGIT_VALID[0]=1 exactly 6 cycles after the change, with no ERR.
- Full frame: scan digits 0..7 showing values 7,6,5,4,3,2,1,0, each held 10 cycles → FRAME_DONE single pulse on the digit-7 capture edge, DIGITS=32'h01234567, DIGIT_VALID=8'hFF.
- Glitch: a 3-cycle AN_IN=11111101 pulse between blanks with SETTLE_CYCLES=4 → no capture, no ERR, outputs unchanged.
- Illegal anode: AN_IN=11111100 held 10 cycles → exactly one ERR pulse, no digit or seen-mask change, no FRAME_DONE.
- Unknown pattern: digit 3 with SEG_IN=0001000 → macro undefined: DIGITS[15:12]=F, DIGIT_VALID[3]=0, one ERR pulse; macro defined: DIGITS[15:12]=A, DIGIT_VALID[3]=1, no ERR.
- Reset mid-frame: capture digits 0..4, assert RST for 1 cycle, then capture digits 5..7 → no FRAME_DONE; DIGITS zero except digits 5..7.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receiving side of an 8-digit multiplexed 7-segment display. The anode and
// segment pins are synchronised, held to a stability window to reject scan
// transitions and ghosting, and each captured digit is decoded back to a
// 4-bit value. A parallel snapshot of all eight digits is kept, with a strobe
// when every digit has been seen since the previous strobe.
//
// Optional feature: define SEG7_SCAN_HEX_EN to also accept the hex glyphs
// A, b, C, d, E, F as known patterns.
//
// Parameters:
//   SETTLE_CYCLES  cycles the anode/segment pair must hold before capture
//                  (2..65535)
//
// Ports:
//   CLK100MHZ    in   system clock
//   RST          in   asynchronous active-high reset
//   AN_IN[7:0]   in   anode lines, active-low, bit i = digit i
//   SEG_IN[6:0]  in   segments {a,b,c,d,e,f,g}, active-low
//   DIGITS[31:0] out  decoded values, digit i at [4i+3:4i]
//   DIGIT_VALID  out  bit i = last capture of digit i was a known pattern
//   FRAME_DONE   out  one-cycle pulse when all 8 digits have been captured
//   ERR          out  one-cycle pulse on unknown pattern or illegal anode
// ----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [7:0]  AN_IN,
    input  logic [6:0]  SEG_IN,
    output logic [31:0] DIGITS,
    output logic [7:0]  DIGIT_VALID,
    output logic        FRAME_DONE,
    output logic        ERR
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(SETTLE_CYCLES - 2);

    // Segment decode: returns {known, value}; unknown patterns give value F.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'h10;
            7'b1001111: res = 5'h11;
            7'b0010010: res = 5'h12;
            7'b0000110: res = 5'h13;
            7'b1001100: res = 5'h14;
            7'b0100100: res = 5'h15;
            7'b0100000: res = 5'h16;
            7'b0001111: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0000100: res = 5'h19;
`ifdef SEG7_SCAN_HEX_EN
            7'b0001000: res = 5'h1A;
            7'b1100000: res = 5'h1B;
            7'b0110001: res = 5'h1C;
            7'b1000010: res = 5'h1D;
            7'b0110000: res = 5'h1E;
            7'b0111000: res = 5'h1F;
`else
            // Hex glyphs fall through to the unknown-pattern default.
`endif
            default:    res = 5'h0F;
        endcase
        return res;
    endfunction

    // Anode classification: returns {single digit selected, digit index}.
    function automatic logic [3:0] classify_anode(input logic [7:0] an);
        logic [3:0] res;
        case (an)
            8'b11111110: res = 4'h8;
            8'b11111101: res = 4'h9;
            8'b11111011: res = 4'hA;
            8'b11110111: res = 4'hB;
            8'b11101111: res = 4'hC;
            8'b11011111: res = 4'hD;
            8'b10111111: res = 4'hE;
            8'b01111111: res = 4'hF;
            default:     res = 4'h0;
        endcase
        return res;
    endfunction

    logic [7:0]       an_s1_r, an_p_r, an_prev_r;
    logic [6:0]       seg_s1_r, seg_p_r, seg_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       seen_r;
    logic [31:0]      digits_r;
    logic [7:0]       valid_r;
    logic             frame_r, err_r;

    logic             stable_s, strobe_s;
    logic [3:0]       an_class_s;
    logic             an_hit_s;
    logic [2:0]       an_idx_s;
    logic [4:0]       dec_s;
    logic [7:0]       seen_acc_s;
    logic [31:0]      digits_nxt_s;
    logic [7:0]       valid_nxt_s, seen_nxt_s;
    logic             frame_nxt_s, err_nxt_s;

    assign stable_s   = (an_p_r == an_prev_r) && (seg_p_r == seg_prev_r);
    // One strobe per stable window: only the transition into saturation.
    assign strobe_s   = stable_s && (cnt_r == CNT_ARM);
    assign an_class_s = classify_anode(an_p_r);
    assign an_hit_s   = an_class_s[3];
    assign an_idx_s   = an_class_s[2:0];
    assign dec_s      = decode_seg(seg_p_r);
    assign seen_acc_s = seen_r | (8'd1 << an_idx_s);

    // Input synchroniser, previous-sample copy and stability counter.
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            an_s1_r    <= 8'hFF;
            an_p_r     <= 8'hFF;
            an_prev_r  <= 8'hFF;
            seg_s1_r   <= 7'h7F;
            seg_p_r    <= 7'h7F;
            seg_prev_r <= 7'h7F;
            cnt_r      <= '0;
        end else begin
            an_s1_r    <= AN_IN;
            an_p_r     <= an_s1_r;
            an_prev_r  <= an_p_r;
            seg_s1_r   <= SEG_IN;
            seg_p_r    <= seg_s1_r;
            seg_prev_r <= seg_p_r;
            if (!stable_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Capture decision: digit update, seen-mask tracking and pulse outputs.
    always_comb begin
        digits_nxt_s = digits_r;
        valid_nxt_s  = valid_r;
        seen_nxt_s   = seen_r;
        frame_nxt_s  = 1'b0;
        err_nxt_s    = 1'b0;
        if (strobe_s) begin
            if (an_hit_s) begin
                digits_nxt_s[{an_idx_s, 2'b00} +: 4] = dec_s[3:0];
                valid_nxt_s[an_idx_s] = dec_s[4];
                err_nxt_s = ~dec_s[4];
                if (seen_acc_s == 8'hFF) begin
                    frame_nxt_s = 1'b1;
                    seen_nxt_s  = 8'h00;
                end else begin
                    seen_nxt_s  = seen_acc_s;
                end
            end else if (an_p_r == 8'hFF) begin
                // Blank interval between digits: nothing to capture.
                err_nxt_s = 1'b0;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Output and seen-mask registers.
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            digits_r <= 32'h0;
            valid_r  <= 8'h00;
            seen_r   <= 8'h00;
            frame_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            digits_r <= digits_nxt_s;
            valid_r  <= valid_nxt_s;
            seen_r   <= seen_nxt_s;
            frame_r  <= frame_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign DIGITS      = digits_r;
    assign DIGIT_VALID = valid_r;
    assign FRAME_DONE  = frame_r;
    assign ERR         = err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder with SETTLE_CYCLES = 4. Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns after a rising edge.
// ERR and FRAME_DONE pulses are counted on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  an_in;
    logic [6:0]  seg_in;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;
    int err_cnt = 0;
    int fd_cnt = 0;

    // Active-low glyphs for 0..9, {a..g} = [6:0].
    logic [6:0] glyph [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                               7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .CLK100MHZ   (clk),
        .RST         (rst),
        .AN_IN       (an_in),
        .SEG_IN      (seg_in),
        .DIGITS      (digits),
        .DIGIT_VALID (digit_valid),
        .FRAME_DONE  (frame_done),
        .ERR         (err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        tick(n);
    endtask

    task automatic scan_digit(input int i, input logic [6:0] seg, input int n);
        logic [7:0] one;
        one = 8'd1 << i;
        drive(~one, seg, n);
    endtask

    task automatic do_reset(input string tag);
        drive(8'hFF, 7'h7F, 1);
        rst = 1'b1;
        tick(1);
        check_val({tag, "_digits"}, digits, 32'h0);
        check_val({tag, "_valid"}, {24'h0, digit_valid}, 32'h0);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int         err_base, fd_base;
        logic [31:0] d_snap;
        logic [7:0]  v_snap;

        rst    = 1'b1;
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        tick(2);
        check_val("rst_digits", digits, 32'h0);
        check_val("rst_valid", {24'h0, digit_valid}, 32'h0);
        check_val("rst_frame", {31'h0, frame_done}, 32'h0);
        check_val("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        tick(3);

        // Single digit: update lands exactly SETTLE+2 edges after the change.
        err_base = err_cnt;
        drive(8'hFE, 7'h12, 5);
        check_val("lat_before", {24'h0, digit_valid}, 32'h0);
        tick(1);
        check_val("lat_value", {28'h0, digits[3:0]}, 32'h2);
        check_val("lat_valid", {31'h0, digit_valid[0]}, 32'h1);
        tick(4);
        check_val("lat_err", err_cnt - err_base, 32'h0);

        // Full frame 7,6,...,0 on digits 0..7.
        do_reset("frame_rst");
        err_base = err_cnt;
        fd_base  = fd_cnt;
        for (int i = 0; i < 7; i++) scan_digit(i, glyph[7-i], 10);
        scan_digit(7, glyph[0], 5);
        check_val("frame_pre", {31'h0, frame_done}, 32'h0);
        tick(1);
        check_val("frame_edge", {31'h0, frame_done}, 32'h1);
        tick(1);
        check_val("frame_post", {31'h0, frame_done}, 32'h0);
        tick(3);
        drive(8'hFF, 7'h7F, 10);
        check_val("frame_count", fd_cnt - fd_base, 32'h1);
        check_val("frame_digits", digits, 32'h01234567);
        check_val("frame_valid", {24'h0, digit_valid}, 32'hFF);
        check_val("frame_err", err_cnt - err_base, 32'h0);

        // Glitch of SETTLE-1 cycles: no capture.
        d_snap = digits;
        v_snap = digit_valid;
        err_base = err_cnt;
        fd_base  = fd_cnt;
        drive(8'hFD, 7'h4F, 3);
        drive(8'hFF, 7'h7F, 10);
        check_val("glitch_digits", digits, d_snap);
        check_val("glitch_valid", {24'h0, digit_valid}, {24'h0, v_snap});
        check_val("glitch_err", err_cnt - err_base, 32'h0);
        check_val("glitch_frame", fd_cnt - fd_base, 32'h0);

        // Exactly SETTLE cycles: captured.
        drive(8'hFD, 7'h4F, 4);
        drive(8'hFF, 7'h7F, 10);
        check_val("settle_edge", digits, 32'h01234517);

        // Illegal anode (two digits on).
        d_snap = digits;
        v_snap = digit_valid;
        err_base = err_cnt;
        fd_base  = fd_cnt;
        drive(8'hFC, 7'h12, 10);
        drive(8'hFF, 7'h7F, 10);
        check_val("illegal_err", err_cnt - err_base, 32'h1);
        check_val("illegal_digits", digits, d_snap);
        check_val("illegal_valid", {24'h0, digit_valid}, {24'h0, v_snap});
        check_val("illegal_frame", fd_cnt - fd_base, 32'h0);

        // Hex glyph 'A' on digit 3.
        err_base = err_cnt;
        scan_digit(3, 7'h08, 10);
        drive(8'hFF, 7'h7F, 5);
`ifdef SEG7_SCAN_HEX_EN
        check_val("hex_value", {28'h0, digits[15:12]}, 32'hA);
        check_val("hex_valid", {31'h0, digit_valid[3]}, 32'h1);
        check_val("hex_err", err_cnt - err_base, 32'h0);
`else
        check_val("hex_value", {28'h0, digits[15:12]}, 32'hF);
        check_val("hex_valid", {31'h0, digit_valid[3]}, 32'h0);
        check_val("hex_err", err_cnt - err_base, 32'h1);
`endif

        // Reset mid-frame discards the partial frame.
        do_reset("mid_rst0");
        fd_base = fd_cnt;
        for (int i = 0; i < 5; i++) scan_digit(i, glyph[7-i], 10);
        do_reset("mid_rst1");
        for (int i = 5; i < 8; i++) scan_digit(i, glyph[7-i], 10);
        drive(8'hFF, 7'h7F, 10);
        check_val("mid_frame", fd_cnt - fd_base, 32'h0);
        check_val("mid_digits", digits, 32'h01200000);
        check_val("mid_valid", {24'h0, digit_valid}, 32'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
